// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: reset vector,
// memory geometry, NOP encoding, FSM encoding, the presented-instruction
// payload and the fetch-address range check.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN           = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam int unsigned IMEM_WORDS_DEF = 4096;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] PC_INC         = 32'd4;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

  // Instruction word plus the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // True when pc is word aligned and inside base .. base+4*words-4.
  function automatic logic pc_in_imem(input logic [XLEN-1:0] pc,
                                      input logic [XLEN-1:0] base,
                                      input int unsigned     words);
    logic [XLEN:0] last;
    last = {1'b0, base} + (33'(words - 1) << 2);
    return (pc[1:0] == 2'b00) && (pc >= base) && ({1'b0, pc} <= last);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus.
//   mem_req_o   : request valid (fetch side drives)
//   mem_addr_o  : byte address of the requested word, [1:0]=0
//   mem_ack_i   : response valid, may coincide with mem_req_o
//   mem_rdata_i : instruction word, valid with mem_ack_i
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the 5-stage pipeline. Owns the fetch PC,
// fetches over a req/ack bus, presents instructions to F/D, honours stall
// and delay-slot branch/jump redirects.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   stall_i                : presented instruction must hold
//   redirect_i/_pc_i       : one-cycle taken-branch/jump pulse and target
//   imem                   : instruction-memory bus (master side)
//   instr_valid_o/instr_o/pc_o : presented instruction and its address
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned     IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  fetch_ctrl_if.master    imem,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  fetch_pkt_t      out_q, out_d;
  fetch_pkt_t      hold_q, hold_d;
  logic            valid_q, valid_d;
  logic            redir_pending_q, redir_pending_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic            pc_ok_c;
  logic            ack_c;
  logic [XLEN-1:0] rdata_c;
  logic [XLEN-1:0] succ_pc_c;

  assign pc_ok_c = pc_in_imem(fetch_pc_q, RESET_PC, IMEM_WORDS);

  // Request is a decode of registered state; reset gates it so nothing is
  // requested while reset is held and a fresh request goes out the first
  // cycle reset is low.
  assign imem.mem_req_o  = !reset && (state_q == ST_REQ) && pc_ok_c;
  assign imem.mem_addr_o = fetch_pc_q;

  assign instr_valid_o = valid_q;
  assign instr_o       = out_q.instr;
  assign pc_o          = out_q.pc;

  // Next-state and datapath decode.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    out_d           = out_q;
    hold_d          = hold_q;
    valid_d         = valid_q;
    redir_pending_d = redir_pending_q;
    redir_pc_d      = redir_pc_q;

    // An unfetchable PC completes at once with a NOP so the PC keeps moving.
    ack_c   = (state_q == ST_REQ) && (!pc_ok_c || imem.mem_ack_i);
    rdata_c = pc_ok_c ? imem.mem_rdata_i : NOP_INSTR;

    if (redirect_i) begin
      succ_pc_c = redirect_pc_i;
    end else if (redir_pending_q) begin
      succ_pc_c = redir_pc_q;
    end else begin
      succ_pc_c = fetch_pc_q + PC_INC;
    end

    // A redirect with no successor computed this cycle is parked until the
    // next completed fetch; a later redirect overwrites it.
    if (redirect_i && !ack_c) begin
      redir_pending_d = 1'b1;
      redir_pc_d      = redirect_pc_i;
    end

    unique case (state_q)
      ST_REQ: begin
        if (ack_c) begin
          fetch_pc_d      = succ_pc_c;
          redir_pending_d = 1'b0;
          if (stall_i) begin
            hold_d  = '{instr: rdata_c, pc: fetch_pc_q};
            state_d = ST_HOLD;
          end else begin
            out_d   = '{instr: rdata_c, pc: fetch_pc_q};
            valid_d = 1'b1;
          end
        end else if (!stall_i) begin
          valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          out_d   = hold_q;
          valid_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_REQ;
      fetch_pc_q      <= RESET_PC;
      out_q           <= '{instr: NOP_INSTR, pc: RESET_PC};
      hold_q          <= '{instr: NOP_INSTR, pc: RESET_PC};
      valid_q         <= 1'b0;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= RESET_PC;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      out_q           <= out_d;
      hold_q          <= hold_d;
      valid_q         <= valid_d;
      redir_pending_q <= redir_pending_d;
      redir_pc_q      <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory model with programmable wait
// states, scoreboard of expected (pc, instr) deliveries, direct checks on
// the request side.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int unsigned wait_states;
  int unsigned wait_cnt = 0;
  logic        ack_force;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc    = '0;

  fetch_ctrl_if mem();

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (mem),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic in_imem(input logic [31:0] a);
    return (a >= 32'h0000_3000) && (a <= 32'h0000_3000 + 32'd16380) && (a[1:0] == 2'b00);
  endfunction

  // Memory: acks once a request has waited wait_states cycles.
  always @(posedge clk) begin
    if (mem.mem_req_o && !mem.mem_ack_i) wait_cnt <= wait_cnt + 1;
    else                                 wait_cnt <= 0;
  end
  assign mem.mem_ack_i   = ack_force || (mem.mem_req_o && (wait_cnt >= wait_states));
  assign mem.mem_rdata_i = mem_word(mem.mem_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = in_imem(a) ? mem_word(a) : 32'h0000_0000;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard: a delivery is a valid instruction not identical to the one
  // presented the previous cycle (a stalled instruction is counted once).
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid_o && !(prev_valid && pc_o == prev_pc)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pc", pc_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", pc_o, e.pc);
          check("sb_instr", instr_o, e.instr);
        end
      end
      prev_valid = instr_valid_o;
      prev_pc    = pc_o;
    end
  end

  initial begin
    logic exp_v [6];
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    wait_states = 0; ack_force = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_req", 32'(mem.mem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_pc", pc_o, 32'h0000_3000);
    check("rst_instr", instr_o, 32'h0);

    // Zero-wait stream
    push_exp(32'h3000); push_exp(32'h3004); push_exp(32'h3008);
    reset = 1'b0;
    #1;
    check("first_req", 32'(mem.mem_req_o), 32'd1);
    check("first_addr", mem.mem_addr_o, 32'h3000);
    check("first_valid", 32'(instr_valid_o), 32'd0);
    tick();                                           // pc_o 3000
    check("zw_valid", 32'(instr_valid_o), 32'd1);
    check("zw_addr", mem.mem_addr_o, 32'h3004);
    tick();                                           // pc_o 3004, ack 3008
    check("zw_ack", 32'(mem.mem_ack_i), 32'd1);
    check("zw_addr2", mem.mem_addr_o, 32'h3008);

    // Stall at ack of 0x3008 for 3 cycles
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_req", 32'(mem.mem_req_o), 32'd0);
      check("hold_pc", pc_o, 32'h3004);
    end
    stall_i = 1'b0;
    wait_states = 2;
    tick();                                           // pc_o 3008
    check("rel_pc", pc_o, 32'h3008);
    check("rel_req", 32'(mem.mem_req_o), 32'd1);
    check("rel_addr", mem.mem_addr_o, 32'h300C);

    // Two wait states, then redirect in the ack cycle of 0x3010
    push_exp(32'h300C); push_exp(32'h3010); push_exp(32'h3040);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ws_valid", 32'(instr_valid_o), 32'(exp_v[i]));
      if (i < 2)            check("ws_addr_300c", mem.mem_addr_o, 32'h300C);
      if (i == 3 || i == 4) check("ws_addr_3010", mem.mem_addr_o, 32'h3010);
      if (i == 4) begin
        check("ws_ack", 32'(mem.mem_ack_i), 32'd1);
        redirect_i = 1'b1; redirect_pc_i = 32'h3040;
      end
      if (i == 5) redirect_i = 1'b0;
    end
    check("redir_addr", mem.mem_addr_o, 32'h3040);

    // Redirect one cycle before ack goes through the pending latch
    push_exp(32'h3010); push_exp(32'h3040);
    tick();
    check("pend_noack", 32'(mem.mem_ack_i), 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h3010;
    tick();
    check("pend_ack", 32'(mem.mem_ack_i), 32'd1);
    redirect_i = 1'b0;
    tick();
    check("pend_addr", mem.mem_addr_o, 32'h3010);
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h3040;
    tick();
    redirect_i = 1'b0;
    tick();
    check("pend_addr2", mem.mem_addr_o, 32'h3040);

    // Out-of-range: redirect to 0 gives NOPs with no requests
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    tick();
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("oor_req", 32'(mem.mem_req_o), 32'd0);
    end
    push_exp(32'h3000);
    redirect_i = 1'b1; redirect_pc_i = 32'h3000;
    tick();                                           // pc_o 8, req 3000
    redirect_i = 1'b0;
    check("resume_req", 32'(mem.mem_req_o), 32'd1);
    check("resume_addr", mem.mem_addr_o, 32'h3000);
    tick(); tick(); tick();                           // pc_o 3000, req 3004

    // Reset mid-request with an ack arriving during reset
    check("mid_addr", mem.mem_addr_o, 32'h3004);
    reset = 1'b1;
    tick();
    check("mrst_req", 32'(mem.mem_req_o), 32'd0);
    check("mrst_valid", 32'(instr_valid_o), 32'd0);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    push_exp(32'h3000);
    reset = 1'b0;
    #1;
    check("post_rst_req", 32'(mem.mem_req_o), 32'd1);
    check("post_rst_addr", mem.mem_addr_o, 32'h3000);
    check("post_rst_valid", 32'(instr_valid_o), 32'd0);
    tick();
    check("post_rst_valid1", 32'(instr_valid_o), 32'd0);
    tick();
    check("post_rst_valid2", 32'(instr_valid_o), 32'd0);
    tick();
    check("post_rst_valid3", 32'(instr_valid_o), 32'd1);
    tick(); tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
